mc_ctrl_hs: RTL and testbench
=============================

# mc_ctrl_hs

Parametrised multi-cycle MIPS control unit with a memory ready handshake, instruction-retire counting and fault detection. It drives the same datapath control set as the existing multi-cycle controller. Unlike that controller, it holds memory requests until `mem_ready`, counts retired instructions, and traps illegal opcodes and memory timeouts. It sits between the instruction/data memory port and the multi-cycle datapath in the processor top.

## Interface
- `MEM_TIMEOUT`, 16 — max cycles a memory request may wait for `mem_ready`; range 1..65535.
- `RETIRE_W`, 32 — width of retired-instruction counter.
- `clk` in 1 — rising-edge clock.
- `rst` in 1 — asynchronous, active-low reset.
- `opcode` in 6 — IR[31:26].
- `func` in 6 — IR[5:0].
- `mem_ready` in 1 — memory completes current request this cycle.
- `AluOperation` out 3 — 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `PCSrc` out 2 — 00 ALU result, 01 ALUOut, 10 jump target, 11 register A.
- `AluSrcB` out 2 — 00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- `AluSrcA`, `RegDst`, `RegWrite`, `MemToReg`, `link`, `IRWrite`, `IorD`, `MemRead`, `MemWrite`, `PCWrite`, `PCWriteCond`, `branch` out 1 each — datapath strobes.
- `retired` out RETIRE_W — count of completed instructions; wraps.
- `fault` out 1 — sticky fault flag.
- `fault_code` out 2 — 00 none, 01 memory timeout, 10 illegal instruction.

## Operation
- Outputs are Moore, decoded from state, with one exception: `IRWrite`/`PCWrite` in FETCH are gated by `mem_ready`.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXR, RWB, EXI, IWB, BEQ, JMP, JAL, JR, FAULT.
- FETCH: IorD=0, MemRead=1, AluSrcA=0, AluSrcB=01, add.
  - On `mem_ready`: IRWrite=1, PCWrite=1, PCSrc=00, then go to DECODE. Otherwise stay.
- DECODE: AluSrcB=11, add (branch target into ALUOut). Dispatch on `opcode`:
  - 000000: func 001000 → JR; add/sub/and/or/slt funcs → EXR; other func → FAULT(10).
  - 100011, 101011 → MEMADR.
  - 001000, 001010, 001100 → EXI.
  - 000100 → BEQ.
  - 000010 → JMP.
  - 000011 → JAL.
  - Any other opcode → FAULT(10).
- MEMADR: AluSrcA=1, AluSrcB=10, add. Lw → MEMRD, sw → MEMWR.
- MEMRD: IorD=1, MemRead=1, held until `mem_ready`, then → MEMWB.
- MEMWB: RegWrite, MemToReg=1, RegDst=0, then → FETCH.
- MEMWR: IorD=1, MemWrite=1, held until `mem_ready`, then → FETCH.
- EXR: AluSrcA=1, AluSrcB=00, op from func, then → RWB.
- RWB: RegWrite, RegDst=1, then → FETCH.
- EXI: AluSrcA=1, AluSrcB=10; op add/slt/and for addi/slti/andi respectively; then → IWB.
- IWB: RegWrite, RegDst=0, then → FETCH.
- BEQ: AluSrcA=1, AluSrcB=00, sub, PCWriteCond=1, branch=1, PCSrc=01, then → FETCH.
- JMP: PCWrite, PCSrc=10, then → FETCH.
- JAL: PCWrite, PCSrc=10, RegWrite, link=1, then → FETCH.
- JR: PCWrite, PCSrc=11, then → FETCH.
- `retired` increments by 1 on every transition into FETCH from a terminal state (MEMWB, MEMWR, RWB, IWB, BEQ, JMP, JAL, JR).
- FAULT: all strobes 0, `fault`=1, `fault_code` held. Exit only via reset.

## Timing
- Reset (async assert, synchronous-edge deassert behaviour from the flop): state=FETCH, `retired`=0, `fault`=0, `fault_code`=00. All strobes reflect FETCH with `mem_ready` gating.
- Latency with zero wait states:
  - lw: 5 cycles.
  - sw, R-type, I-type: 4 cycles.
  - beq, j, jal, jr: 3 cycles.
- Each memory wait cycle adds 1 cycle.
- Wait counter:
  - Clears on entry to FETCH/MEMRD/MEMWR and on `mem_ready`.
  - Increments each cycle in those states without `mem_ready`.
  - On reaching MEM_TIMEOUT with `mem_ready` low → FAULT(01) next cycle.
  - `mem_ready` high in the timeout cycle wins: completion is taken, no fault.
- `mem_ready` outside memory states is ignored.
- Reset asserted mid-instruction aborts immediately. No partial retire count.

## Configuration
- `MC_TIMEOUT_EN` defined: wait counter and timeout fault are present.
- Not defined: counter is absent; memory states wait indefinitely; `fault_code` 01 is never produced. Illegal-instruction fault remains.

## Structure
- Package `mc_ctrl_pkg`: state enum, opcode/func constants, ALU op codes, PCSrc/AluSrcB codes, fault codes.
- Sub-module `mc_alu_dec`: combinational func/opcode → AluOperation, plus an illegal-func flag.

## Test plan
- Reset, then lw with `mem_ready` tied 1 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite & MemToReg in cycle 5; `retired`=1.
- sw with `mem_ready` low 3 cycles in MEMWR → MemWrite held 4 cycles, single completion, total 7 cycles.
- beq then jal back-to-back → beq: PCWriteCond=1, AluOperation=110 in cycle 3; jal: link=1, RegWrite=1, PCSrc=10; `retired`=2.
- opcode 111111 → FAULT after DECODE, `fault_code`=10; strobes 0 for 10 further cycles; reset clears.
- MEM_TIMEOUT=4 with `mem_ready` never high in FETCH → FAULT(01) after 4 wait cycles. Repeat with `mem_ready` in the 4th cycle → no fault.
- Set `retired` to all-ones via RETIRE_W=4 and 16 j instructions → wraps to 0. Assert reset mid-MEMRD → FETCH, `retired`=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the handshaked multi-cycle MIPS controller.
// Holds the state enum, opcode/func constants, ALU/mux select codes and fault codes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr, StExR, StRwb,
        StExI, StIwb, StBeq, StJmp, StJal, StJr, StFault
    } state_e;

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;
    localparam logic [5:0] FnJr  = 6'b001000;

    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluSlt = 3'b111;

    localparam logic [1:0] PcAlu    = 2'b00;
    localparam logic [1:0] PcAluOut = 2'b01;
    localparam logic [1:0] PcJump   = 2'b10;
    localparam logic [1:0] PcRegA   = 2'b11;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    localparam logic [1:0] FaultNone    = 2'b00;
    localparam logic [1:0] FaultTimeout = 2'b01;
    localparam logic [1:0] FaultIllegal = 2'b10;

    // States whose exit back to FETCH completes an instruction.
    function automatic logic is_terminal(state_e s);
        return s inside {StMemWb, StMemWr, StRwb, StIwb, StBeq, StJmp, StJal, StJr};
    endfunction

endpackage

// File: rtl/mc_ctrl_hs_if.sv
// Controller <-> datapath/memory bundle: IR fields and mem_ready in, control strobes out.
// master = controller side, slave = datapath/memory side.
interface mc_ctrl_hs_if #(
    parameter int unsigned RETIRE_W = 32
);
    logic [5:0]          opcode;
    logic [5:0]          func;
    logic                mem_ready;
    logic [2:0]          AluOperation;
    logic [1:0]          PCSrc;
    logic [1:0]          AluSrcB;
    logic                AluSrcA, RegDst, RegWrite, MemToReg, link, IRWrite, IorD;
    logic                MemRead, MemWrite, PCWrite, PCWriteCond, branch;
    logic [RETIRE_W-1:0] retired;
    logic                fault;
    logic [1:0]          fault_code;

    modport master (
        input  opcode, func, mem_ready,
        output AluOperation, PCSrc, AluSrcB, AluSrcA, RegDst, RegWrite, MemToReg, link,
               IRWrite, IorD, MemRead, MemWrite, PCWrite, PCWriteCond, branch,
               retired, fault, fault_code
    );

    modport slave (
        output opcode, func, mem_ready,
        input  AluOperation, PCSrc, AluSrcB, AluSrcA, RegDst, RegWrite, MemToReg, link,
               IRWrite, IorD, MemRead, MemWrite, PCWrite, PCWriteCond, branch,
               retired, fault, fault_code
    );
endinterface

// File: rtl/mc_alu_dec.sv
// ALU operation decode from opcode/func; flags R-type funcs the ALU does not implement.
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] func_i,
    output logic [2:0] alu_op_o,
    output logic       illegal_func_o
);

    always_comb begin
        alu_op_o       = AluAdd;
        illegal_func_o = 1'b0;
        case (opcode_i)
            OpRType: begin
                case (func_i)
                    FnAdd:   alu_op_o = AluAdd;
                    FnSub:   alu_op_o = AluSub;
                    FnAnd:   alu_op_o = AluAnd;
                    FnOr:    alu_op_o = AluOr;
                    FnSlt:   alu_op_o = AluSlt;
                    default: illegal_func_o = 1'b1;
                endcase
            end
            OpSlti:  alu_op_o = AluSlt;
            OpAndi:  alu_op_o = AluAnd;
            OpBeq:   alu_op_o = AluSub;
            default: alu_op_o = AluAdd;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_hs.sv
// Multi-cycle MIPS controller with mem_ready handshake, retire counter and sticky fault trap.
// Define MC_TIMEOUT_EN to add the memory wait counter and timeout fault (code 01).
module mc_ctrl_hs
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned RETIRE_W    = 32
) (
    input logic          clk,
    input logic          rst,
    mc_ctrl_hs_if.master ctrl_io
);

    state_e              state_q, state_d;
    logic [1:0]          fault_code_q, fault_code_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    logic [2:0]          dec_alu_op;
    logic                illegal_func;
    logic                in_mem;
    logic                timeout;

    mc_alu_dec u_alu_dec (
        .opcode_i      (ctrl_io.opcode),
        .func_i        (ctrl_io.func),
        .alu_op_o      (dec_alu_op),
        .illegal_func_o(illegal_func)
    );

    assign in_mem = state_q inside {StFetch, StMemRd, StMemWr};

`ifdef MC_TIMEOUT_EN
    localparam logic [15:0] WaitMax = 16'(MEM_TIMEOUT - 1);
    logic [15:0] wait_q, wait_d;

    // Leaving a memory state, or any completion, clears the count.
    assign wait_d  = (in_mem && !ctrl_io.mem_ready) ? wait_q + 16'd1 : 16'd0;
    assign timeout = in_mem && !ctrl_io.mem_ready && (wait_q == WaitMax);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wait_q <= 16'd0;
        else      wait_q <= wait_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^MEM_TIMEOUT;
    assign timeout        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StFetch;
            fault_code_q <= FaultNone;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            fault_code_q <= fault_code_d;
            retired_q    <= retired_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;
        unique case (state_q)
            StFetch: if (ctrl_io.mem_ready) state_d = StDecode;
            StDecode: begin
                case (ctrl_io.opcode)
                    OpRType: begin
                        if (ctrl_io.func == FnJr) state_d = StJr;
                        else if (illegal_func)    state_d = StFault;
                        else                      state_d = StExR;
                    end
                    OpLw, OpSw:             state_d = StMemAdr;
                    OpAddi, OpSlti, OpAndi: state_d = StExI;
                    OpBeq:                  state_d = StBeq;
                    OpJ:                    state_d = StJmp;
                    OpJal:                  state_d = StJal;
                    default:                state_d = StFault;
                endcase
                if (state_d == StFault) fault_code_d = FaultIllegal;
            end
            StMemAdr: state_d = (ctrl_io.opcode == OpSw) ? StMemWr : StMemRd;
            StMemRd:  if (ctrl_io.mem_ready) state_d = StMemWb;
            StMemWr:  if (ctrl_io.mem_ready) state_d = StFetch;
            StExR:    state_d = StRwb;
            StExI:    state_d = StIwb;
            StMemWb, StRwb, StIwb, StBeq, StJmp, StJal, StJr: state_d = StFetch;
            StFault:  state_d = StFault;
            default:  state_d = StFetch;
        endcase
        // timeout only fires without mem_ready, so it never competes with a completion
        if (timeout) begin
            state_d      = StFault;
            fault_code_d = FaultTimeout;
        end
    end

    assign retired_d = (is_terminal(state_q) && state_d == StFetch) ?
                       retired_q + RETIRE_W'(1) : retired_q;

    always_comb begin
        ctrl_io.AluOperation = 3'b000;
        ctrl_io.PCSrc        = PcAlu;
        ctrl_io.AluSrcB      = SrcBReg;
        ctrl_io.AluSrcA      = 1'b0;
        ctrl_io.RegDst       = 1'b0;
        ctrl_io.RegWrite     = 1'b0;
        ctrl_io.MemToReg     = 1'b0;
        ctrl_io.link         = 1'b0;
        ctrl_io.IRWrite      = 1'b0;
        ctrl_io.IorD         = 1'b0;
        ctrl_io.MemRead      = 1'b0;
        ctrl_io.MemWrite     = 1'b0;
        ctrl_io.PCWrite      = 1'b0;
        ctrl_io.PCWriteCond  = 1'b0;
        ctrl_io.branch       = 1'b0;
        unique case (state_q)
            StFetch: begin
                ctrl_io.MemRead      = 1'b1;
                ctrl_io.AluSrcB      = SrcBFour;
                ctrl_io.AluOperation = AluAdd;
                ctrl_io.IRWrite      = ctrl_io.mem_ready;
                ctrl_io.PCWrite      = ctrl_io.mem_ready;
            end
            StDecode: begin
                ctrl_io.AluSrcB      = SrcBImmSh;
                ctrl_io.AluOperation = AluAdd;
            end
            StMemAdr: begin
                ctrl_io.AluSrcA      = 1'b1;
                ctrl_io.AluSrcB      = SrcBImm;
                ctrl_io.AluOperation = AluAdd;
            end
            StMemRd: begin
                ctrl_io.IorD    = 1'b1;
                ctrl_io.MemRead = 1'b1;
            end
            StMemWb: begin
                ctrl_io.RegWrite = 1'b1;
                ctrl_io.MemToReg = 1'b1;
            end
            StMemWr: begin
                ctrl_io.IorD     = 1'b1;
                ctrl_io.MemWrite = 1'b1;
            end
            StExR: begin
                ctrl_io.AluSrcA      = 1'b1;
                ctrl_io.AluOperation = dec_alu_op;
            end
            StRwb: begin
                ctrl_io.RegWrite = 1'b1;
                ctrl_io.RegDst   = 1'b1;
            end
            StExI: begin
                ctrl_io.AluSrcA      = 1'b1;
                ctrl_io.AluSrcB      = SrcBImm;
                ctrl_io.AluOperation = dec_alu_op;
            end
            StIwb: ctrl_io.RegWrite = 1'b1;
            StBeq: begin
                ctrl_io.AluSrcA      = 1'b1;
                ctrl_io.AluOperation = AluSub;
                ctrl_io.PCWriteCond  = 1'b1;
                ctrl_io.branch       = 1'b1;
                ctrl_io.PCSrc        = PcAluOut;
            end
            StJmp: begin
                ctrl_io.PCWrite = 1'b1;
                ctrl_io.PCSrc   = PcJump;
            end
            StJal: begin
                ctrl_io.PCWrite  = 1'b1;
                ctrl_io.PCSrc    = PcJump;
                ctrl_io.RegWrite = 1'b1;
                ctrl_io.link     = 1'b1;
            end
            StJr: begin
                ctrl_io.PCWrite = 1'b1;
                ctrl_io.PCSrc   = PcRegA;
            end
            default: ;
        endcase
    end

    assign ctrl_io.retired    = retired_q;
    assign ctrl_io.fault      = (state_q == StFault);
    assign ctrl_io.fault_code = fault_code_q;

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Bench for mc_ctrl_hs: instruction-level model checked every cycle plus directed literal checks.
module tb_mc_ctrl_hs;

    localparam int unsigned TO = 4;
    localparam int unsigned RW = 4;

    localparam int CLw = 0, CSw = 1, CR = 2, CI = 3, CBeq = 4, CJ = 5, CJal = 6, CJr = 7;
    localparam int CBad = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    mc_ctrl_hs_if #(.RETIRE_W(RW)) bus ();

    mc_ctrl_hs #(.MEM_TIMEOUT(TO), .RETIRE_W(RW)) dut (
        .clk    (clk),
        .rst    (rst),
        .ctrl_io(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic RegDst, RegWrite, MemToReg, link, IRWrite, IorD, MemRead, MemWrite;
        logic PCWrite, PCWriteCond, branch;
    } str_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000: begin
                if (fn == 6'b001000) return CJr;
                if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) return CR;
                return CBad;
            end
            6'b100011: return CLw;
            6'b101011: return CSw;
            6'b001000, 6'b001010, 6'b001100: return CI;
            6'b000100: return CBeq;
            6'b000010: return CJ;
            6'b000011: return CJal;
            default:   return CBad;
        endcase
    endfunction

    function automatic int ins_len(input int c);
        if (c == CLw) return 5;
        if (c == CSw || c == CR || c == CI) return 4;
        return 3;
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic [2:0] i_alu(input logic [5:0] op);
        if (op == 6'b001010) return 3'b111;
        if (op == 6'b001100) return 3'b000;
        return 3'b010;
    endfunction

    // Instruction-level model: step counts cycles within the current instruction.
    int          m_step = 0, m_cls = 0, m_wait = 0;
    int unsigned m_ret = 0;
    bit          m_fault = 1'b0;
    logic [1:0]  m_code = 2'b00;

    always @(negedge clk) begin : cmp
        str_t       e, act;
        logic       rdy, mem_step;
        logic       c_srca, c_alu, c_srcb, c_pc, e_srca;
        logic [2:0] e_alu;
        logic [1:0] e_srcb, e_pc;
        if (!rst) begin
            m_step = 0; m_wait = 0; m_ret = 0; m_fault = 1'b0; m_code = 2'b00;
        end
        rdy = bus.mem_ready;
        e = '0;
        {c_srca, c_alu, c_srcb, c_pc} = 4'b0000;
        e_srca = 1'b0; e_alu = 3'b000; e_srcb = 2'b00; e_pc = 2'b00;
        if (!m_fault) begin
            case (m_step)
                0: begin
                    e.MemRead = 1'b1; e.IRWrite = rdy; e.PCWrite = rdy;
                    {c_srca, c_alu, c_srcb, c_pc} = 4'b1111;
                    e_alu = 3'b010; e_srcb = 2'b01;
                end
                1: begin
                    {c_alu, c_srcb} = 2'b11; e_alu = 3'b010; e_srcb = 2'b11;
                end
                2: begin
                    case (m_cls)
                        CLw, CSw: begin
                            {c_srca, c_alu, c_srcb} = 3'b111;
                            e_srca = 1'b1; e_alu = 3'b010; e_srcb = 2'b10;
                        end
                        CR: begin
                            {c_srca, c_alu, c_srcb} = 3'b111;
                            e_srca = 1'b1; e_alu = r_alu(bus.func); e_srcb = 2'b00;
                        end
                        CI: begin
                            {c_srca, c_alu, c_srcb} = 3'b111;
                            e_srca = 1'b1; e_alu = i_alu(bus.opcode); e_srcb = 2'b10;
                        end
                        CBeq: begin
                            {c_srca, c_alu, c_srcb, c_pc} = 4'b1111;
                            e_srca = 1'b1; e_alu = 3'b110; e_srcb = 2'b00; e_pc = 2'b01;
                            e.PCWriteCond = 1'b1; e.branch = 1'b1;
                        end
                        CJ:   begin e.PCWrite = 1'b1; c_pc = 1'b1; e_pc = 2'b10; end
                        CJal: begin
                            e.PCWrite = 1'b1; e.RegWrite = 1'b1; e.link = 1'b1;
                            c_pc = 1'b1; e_pc = 2'b10;
                        end
                        CJr:  begin e.PCWrite = 1'b1; c_pc = 1'b1; e_pc = 2'b11; end
                        default: ;
                    endcase
                end
                3: begin
                    case (m_cls)
                        CLw: begin e.IorD = 1'b1; e.MemRead = 1'b1; end
                        CSw: begin e.IorD = 1'b1; e.MemWrite = 1'b1; end
                        CR:  begin e.RegWrite = 1'b1; e.RegDst = 1'b1; end
                        CI:  e.RegWrite = 1'b1;
                        default: ;
                    endcase
                end
                default: begin e.RegWrite = 1'b1; e.MemToReg = 1'b1; end
            endcase
        end
        act = {bus.RegDst, bus.RegWrite, bus.MemToReg, bus.link, bus.IRWrite, bus.IorD,
               bus.MemRead, bus.MemWrite, bus.PCWrite, bus.PCWriteCond, bus.branch};
        check("strobes", 32'(act), 32'(e));
        if (c_srca) check("AluSrcA", 32'(bus.AluSrcA), 32'(e_srca));
        if (c_alu)  check("AluOperation", 32'(bus.AluOperation), 32'(e_alu));
        if (c_srcb) check("AluSrcB", 32'(bus.AluSrcB), 32'(e_srcb));
        if (c_pc)   check("PCSrc", 32'(bus.PCSrc), 32'(e_pc));
        check("retired", 32'(bus.retired), m_ret % (32'd1 << RW));
        check("fault", 32'(bus.fault), 32'(m_fault));
        check("fault_code", 32'(bus.fault_code), 32'(m_code));
        // advance to what the next rising edge must produce
        if (rst && !m_fault) begin
            mem_step = (m_step == 0) || (m_step == 3 && (m_cls == CLw || m_cls == CSw));
            if (mem_step) begin
                if (rdy) begin
                    m_wait = 0;
                    if (m_step == 0)        m_step = 1;
                    else if (m_cls == CLw)  m_step = 4;
                    else begin m_step = 0; m_ret++; end
                end else begin
                    m_wait++;
`ifdef MC_TIMEOUT_EN
                    if (m_wait == int'(TO)) begin m_fault = 1'b1; m_code = 2'b01; end
`endif
                end
            end else if (m_step == 1) begin
                m_cls = classify(bus.opcode, bus.func);
                if (m_cls == CBad) begin m_fault = 1'b1; m_code = 2'b10; end
                else m_step = 2;
            end else if (m_step == ins_len(m_cls) - 1) begin
                m_step = 0; m_wait = 0; m_ret++;
            end else begin
                m_step++;
            end
        end
    end

    logic       cap_rw[16], cap_mtr[16], cap_mw[16], cap_pcwc[16], cap_link[16], cap_any[16];
    logic [2:0] cap_alu[16];
    logic [1:0] cap_pc[16];

    // Starts and ends 1 time unit after a rising edge; rdy[i] drives mem_ready in cycle i.
    task automatic run(input logic [5:0] op, input logic [5:0] fn, input int n,
                       input logic [31:0] rdy);
        bus.opcode = op;
        bus.func   = fn;
        for (int i = 0; i < n; i++) begin
            bus.mem_ready = rdy[i];
            #1;
            if (i < 16) begin
                cap_rw[i]   = bus.RegWrite;
                cap_mtr[i]  = bus.MemToReg;
                cap_mw[i]   = bus.MemWrite;
                cap_pcwc[i] = bus.PCWriteCond;
                cap_link[i] = bus.link;
                cap_alu[i]  = bus.AluOperation;
                cap_pc[i]   = bus.PCSrc;
                cap_any[i]  = |{bus.RegDst, bus.RegWrite, bus.MemToReg, bus.link, bus.IRWrite,
                                bus.IorD, bus.MemRead, bus.MemWrite, bus.PCWrite,
                                bus.PCWriteCond, bus.branch};
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        check("rst_retired", 32'(bus.retired), 32'd0);
        check("rst_fault", 32'(bus.fault), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int n;
        bus.opcode = 6'd0;
        bus.func = 6'd0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_MemRead", 32'(bus.MemRead), 32'd1);
        check("reset_IRWrite_gated", 32'(bus.IRWrite), 32'd0);
        check("reset_code", 32'(bus.fault_code), 32'd0);
        bus.mem_ready = 1'b1;
        #1;
        check("reset_IRWrite_ready", 32'(bus.IRWrite), 32'd1);
        check("reset_PCWrite_ready", 32'(bus.PCWrite), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;

        run(6'b100011, 6'd0, 5, 32'h1f);
        check("lw_RegWrite_c5", 32'(cap_rw[4]), 32'd1);
        check("lw_MemToReg_c5", 32'(cap_mtr[4]), 32'd1);
        check("lw_MemToReg_c4", 32'(cap_mtr[3]), 32'd0);
        check("lw_retired", 32'(bus.retired), 32'd1);

        run(6'b101011, 6'd0, 7, 32'h41);
        n = 0;
        for (int i = 0; i < 7; i++) n += int'(cap_mw[i]);
        check("sw_MemWrite_cycles", 32'(n), 32'd4);
        check("sw_retired", 32'(bus.retired), 32'd2);

        run(6'b000100, 6'd0, 3, 32'h7);
        check("beq_PCWriteCond", 32'(cap_pcwc[2]), 32'd1);
        check("beq_alu", 32'(cap_alu[2]), 32'b110);
        run(6'b000011, 6'd0, 3, 32'h7);
        check("jal_link", 32'(cap_link[2]), 32'd1);
        check("jal_RegWrite", 32'(cap_rw[2]), 32'd1);
        check("jal_PCSrc", 32'(cap_pc[2]), 32'b10);
        check("beq_jal_retired", 32'(bus.retired), 32'd4);

        run(6'b000000, 6'b100010, 4, 32'hf);
        check("sub_alu", 32'(cap_alu[2]), 32'b110);
        check("sub_RegWrite", 32'(cap_rw[3]), 32'd1);
        run(6'b001010, 6'd0, 4, 32'hf);
        check("slti_alu", 32'(cap_alu[2]), 32'b111);
        run(6'b000000, 6'b100101, 4, 32'hf);
        check("or_alu", 32'(cap_alu[2]), 32'b001);
        run(6'b000000, 6'b001000, 3, 32'h7);
        check("jr_PCSrc", 32'(cap_pc[2]), 32'b11);
        check("mix_retired", 32'(bus.retired), 32'd8);

        run(6'b111111, 6'd0, 2, 32'h3);
        run(6'b111111, 6'd0, 10, 32'h3ff);
        n = 0;
        for (int i = 0; i < 10; i++) n += int'(cap_any[i]);
        check("fault_strobes_active", 32'(n), 32'd0);
        check("illegal_fault", 32'(bus.fault), 32'd1);
        check("illegal_code", 32'(bus.fault_code), 32'b10);
        do_reset();

        run(6'b000000, 6'b111111, 2, 32'h3);
        check("badfunc_code", 32'(bus.fault_code), 32'b10);
        do_reset();

`ifdef MC_TIMEOUT_EN
        run(6'b000010, 6'd0, 3, 32'h0);
        check("to_before", 32'(bus.fault), 32'd0);
        run(6'b000010, 6'd0, 1, 32'h0);
        check("to_fault", 32'(bus.fault), 32'd1);
        check("to_code", 32'(bus.fault_code), 32'b01);
        do_reset();
        run(6'b000010, 6'd0, 6, 32'h08);
        check("to_ready_last_fault", 32'(bus.fault), 32'd0);
        check("to_ready_last_retired", 32'(bus.retired), 32'd1);
`else
        run(6'b000010, 6'd0, 5 * TO, 32'h0);
        check("nto_fault", 32'(bus.fault), 32'd0);
        run(6'b000010, 6'd0, 3, 32'h7);
        check("nto_retired", 32'(bus.retired), 32'd1);
`endif
        do_reset();

        for (int k = 0; k < 15; k++) run(6'b000010, 6'd0, 3, 32'h7);
        check("wrap_ones", 32'(bus.retired), 32'hf);
        run(6'b000010, 6'd0, 3, 32'h7);
        check("wrap_zero", 32'(bus.retired), 32'd0);
        run(6'b000010, 6'd0, 3, 32'h7);
        run(6'b100011, 6'd0, 4, 32'h1);
        check("memrd_IorD", 32'(bus.IorD), 32'd1);
        rst = 1'b0;
        #1;
        check("abort_retired", 32'(bus.retired), 32'd0);
        check("abort_IorD", 32'(bus.IorD), 32'd0);
        check("abort_MemRead", 32'(bus.MemRead), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        run(6'b000010, 6'd0, 3, 32'h7);
        check("after_abort_retired", 32'(bus.retired), 32'd1);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
